// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NREQ producers, the round-robin arbiter and the async FIFO.
// master = producer/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    accept;
    logic               fifo_w_en;
    logic [DW-1:0]      fifo_data_in;
    logic               fifo_full;
    logic               fifo_amf;
    logic               busy;
    logic [7:0]         stall_cnt;

    // A word moves when req[i] and accept[i] are both high in the same cycle;
    // req must stay high with stable data until accept or a voluntary release.
    modport master (
        output req, req_data, fifo_full, fifo_amf,
        input  gnt, accept, fifo_w_en, fifo_data_in, busy, stall_cnt
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_amf,
        output gnt, accept, fifo_w_en, fifo_data_in, busy, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port; busy exposes the FSM state.
// Optional: define FIFO_WR_ARB_AMF_THROTTLE_EN to hold off new grants while fifo_amf=1.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int MAXBURST = 4
) (
    input  logic              wclk,
    input  logic              rstn,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t          state;
    logic [NREQ-1:0] gnt_q;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [BW-1:0]   beat_cnt;
    logic [7:0]      stall_q;

    logic [OW-1:0]   sel;
    logic [OW-1:0]   idx;
    logic            found;
    logic            any_req;
    logic            owner_req;
    logic            w_en;
    logic            throttle;
    logic            last_beat;

`ifdef FIFO_WR_ARB_AMF_THROTTLE_EN
    assign throttle = bus.fifo_amf;
`else
    logic amf_unused;
    assign throttle   = 1'b0;
    assign amf_unused = bus.fifo_amf;
`endif

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(last_owner) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req   = |bus.req;
    assign owner_req = bus.req[owner];
    assign w_en      = (state == BURST) && owner_req && !bus.fifo_full;
    assign last_beat = (beat_cnt == BW'(MAXBURST - 1));

    assign bus.gnt          = gnt_q;
    assign bus.busy         = (state == BURST);
    assign bus.stall_cnt    = stall_q;
    assign bus.fifo_w_en    = w_en;
    assign bus.accept       = w_en ? (NREQ'(1) << owner) : '0;
    assign bus.fifo_data_in = (state == BURST) ? bus.req_data[owner*DW +: DW] : '0;

    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            gnt_q      <= '0;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            beat_cnt   <= '0;
            stall_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && found && !throttle) begin
                        state      <= BURST;
                        gnt_q      <= NREQ'(1) << sel;
                        owner      <= sel;
                        last_owner <= sel;
                        beat_cnt   <= '0;
                    end else if (any_req && stall_q != 8'hFF) begin
                        stall_q <= stall_q + 8'd1;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else if (bus.fifo_full) begin
                        if (stall_q != 8'hFF)
                            stall_q <= stall_q + 8'd1;
                    end else if (last_beat) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the grant/burst rules and a write-data scoreboard.
module tb_fifo_wr_arbiter;
    localparam int NREQ     = 4;
    localparam int DW       = 4;
    localparam int MAXBURST = 4;
`ifdef FIFO_WR_ARB_AMF_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic wclk = 1'b0;
    logic rstn = 1'b1;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST)) dut (
        .wclk (wclk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] src_mem [NREQ][256];
    int src_r [NREQ];
    int src_w [NREQ];
    logic [NREQ-1:0] pause;
    logic [NREQ-1:0] acc_q;
    bit rand_mode = 1'b0;
    int cyc = 0;
    int wr_cnt [NREQ];
    int wr_total = 0;
    logic [DW-1:0] wr_log[$];
    int wr_cyc[$];
    int gnt_log[$];

    int m_owner = -1;
    int m_beats = 0;
    int m_last  = NREQ - 1;
    int m_stall = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_word(input int i, input logic [DW-1:0] w);
        src_mem[i][src_w[i] % 256] = w;
        src_w[i]++;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NREQ; i++) src_r[i] = src_w[i];
    endtask

    task automatic apply_inputs();
        logic [NREQ-1:0]    r;
        logic [NREQ*DW-1:0] d;
        r = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_w[i] != src_r[i] && !pause[i]) begin
                r[i]         = 1'b1;
                d[i*DW +: DW] = src_mem[i][src_r[i] % 256];
            end
        end
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic drv_step();
        for (int i = 0; i < NREQ; i++)
            if (acc_q[i] && src_r[i] != src_w[i]) src_r[i]++;
    endtask

    task automatic randomize_inputs();
        bus.fifo_full = ($urandom_range(0, 2) == 0);
        bus.fifo_amf  = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 7) == 0) pause[i] = ~pause[i];
            if (src_r[i] == src_w[i] && $urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) push_word(i, DW'($urandom));
            end
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        gnt_log.delete();
        wr_total = 0;
        for (int i = 0; i < NREQ; i++) wr_cnt[i] = 0;
    endtask

    task automatic reset_dut();
        @(negedge wclk); #1;
        rstn = 1'b0;
        clear_srcs();
        pause         = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_amf  = 1'b0;
        apply_inputs();
        @(negedge wclk); #1;
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic wait_src(input int i, input int n, input int budget, input string name);
        int c;
        c = 0;
        while (wr_cnt[i] < n && c < budget) begin
            @(negedge wclk); #1;
            c++;
        end
        chk(name, wr_cnt[i], n);
    endtask

    // Inputs change only on the falling edge (+0 from here, +1 from tests).
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            src_r[i]  = 0;
            src_w[i]  = 0;
            wr_cnt[i] = 0;
        end
        pause         = '0;
        acc_q         = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_amf  = 1'b0;
        apply_inputs();
        forever begin
            @(negedge wclk);
            drv_step();
            if (rand_mode) randomize_inputs();
            apply_inputs();
        end
    end

    // ---------------- write monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge wclk);
            cyc++;
            acc_q = rstn ? bus.accept : '0;
            if (rstn && bus.fifo_w_en) begin
                int src;
                src = 0;
                for (int i = 0; i < NREQ; i++) if (bus.accept[i]) src = i;
                wr_cnt[src]++;
                wr_total++;
                wr_log.push_back(bus.fifo_data_in);
                wr_cyc.push_back(cyc);
                chk("no_write_when_full", int'(bus.fifo_full), 0);
                chk("sb_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) chk("sb_write_data", int'(bus.fifo_data_in), int'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    initial begin
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_acc;
        logic [NREQ-1:0] prev_gnt;
        logic            e_wen;
        logic [DW-1:0]   e_data;
        prev_gnt = '0;
        forever begin
            @(negedge wclk); #2;
            if (!rstn) begin
                m_owner = -1;
                m_beats = 0;
                m_last  = NREQ - 1;
                m_stall = 0;
                exp_q.delete();
            end
            e_gnt  = '0;
            e_acc  = '0;
            e_wen  = 1'b0;
            e_data = '0;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                e_data = bus.req_data[m_owner*DW +: DW];
                e_wen  = bus.req[m_owner] && !bus.fifo_full;
                if (e_wen) e_acc[m_owner] = 1'b1;
            end
            chk("gnt", int'(bus.gnt), int'(e_gnt));
            chk("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
            chk("fifo_w_en", int'(bus.fifo_w_en), int'(e_wen));
            chk("accept", int'(bus.accept), int'(e_acc));
            chk("fifo_data_in", int'(bus.fifo_data_in), int'(e_data));
            chk("stall_cnt", int'(bus.stall_cnt), m_stall);

            if (bus.gnt != '0 && prev_gnt == '0)
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gnt_log.push_back(i);
            prev_gnt = bus.gnt;

            if (e_wen) exp_q.push_back(e_data);

            if (rstn) begin
                if (m_owner < 0) begin
                    if (bus.req != '0 && !(THR && bus.fifo_amf)) begin
                        for (int k = 1; k <= NREQ; k++) begin
                            if (bus.req[(m_last + k) % NREQ]) begin
                                m_owner = (m_last + k) % NREQ;
                                break;
                            end
                        end
                        m_last  = m_owner;
                        m_beats = 0;
                    end else if (bus.req != '0) begin
                        m_stall = (m_stall < 255) ? m_stall + 1 : 255;
                    end
                end else if (!bus.req[m_owner]) begin
                    m_owner = -1;
                end else if (bus.fifo_full) begin
                    m_stall = (m_stall < 255) ? m_stall + 1 : 255;
                end else begin
                    m_beats++;
                    if (m_beats == MAXBURST) m_owner = -1;
                end
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        #1 rstn = 1'b0;

        // single requester, 5 words: burst of 4, one idle cycle, then the 5th
        reset_dut();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_stall", int'(bus.stall_cnt), 0);
        chk("rst_w_en", int'(bus.fifo_w_en), 0);
        push_word(0, 4'h3); push_word(0, 4'h5); push_word(0, 4'h7);
        push_word(0, 4'h9); push_word(0, 4'hA);
        apply_inputs();
        @(negedge wclk); #1;
        chk("t1_gnt_latency", int'(bus.gnt), 1);
        wait_src(0, 5, 20, "t1_words");
        chk("t1_w0", int'(wr_log[0]), 3);
        chk("t1_w1", int'(wr_log[1]), 5);
        chk("t1_w2", int'(wr_log[2]), 7);
        chk("t1_w3", int'(wr_log[3]), 9);
        chk("t1_w4", int'(wr_log[4]), 10);
        chk("t1_burst_span", wr_cyc[3] - wr_cyc[0], 3);
        chk("t1_regrant_gap", wr_cyc[4] - wr_cyc[3], 2);

        // all four requesting continuously: rotation 0,1,2,3,0
        reset_dut();
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 8; j++) push_word(i, DW'($urandom));
        apply_inputs();
        wait_src(3, 8, 200, "t2_drain");
        chk("t2_g0", gnt_log[0], 0);
        chk("t2_g1", gnt_log[1], 1);
        chk("t2_g2", gnt_log[2], 2);
        chk("t2_g3", gnt_log[3], 3);
        chk("t2_g4", gnt_log[4], 0);

        // requester 2 stalled by fifo_full for 3 cycles after its 2nd word
        reset_dut();
        for (int j = 0; j < 4; j++) push_word(2, DW'(j + 1));
        apply_inputs();
        wait_src(2, 2, 20, "t3_two_words");
        bus.fifo_full = 1'b1;
        repeat (3) @(negedge wclk);
        #1 bus.fifo_full = 1'b0;
        chk("t3_stall_hold", wr_cnt[2], 2);
        wait_src(2, 4, 20, "t3_words");
        @(negedge wclk); #1;
        chk("t3_stall_cnt", int'(bus.stall_cnt), 3);
        chk("t3_busy_done", int'(bus.busy), 0);

        // requester 1 releases early after 2 words; requester 2 is next
        reset_dut();
        for (int j = 0; j < 4; j++) push_word(1, DW'(j + 5));
        push_word(2, 4'hC); push_word(2, 4'hD);
        apply_inputs();
        wait_src(1, 2, 20, "t4_two_words");
        pause[1] = 1'b1;
        apply_inputs();
        @(negedge wclk); #1;
        chk("t4_gnt_release", int'(bus.gnt), 0);
        @(negedge wclk); #1;
        chk("t4_next_gnt", int'(bus.gnt), 4);
        chk("t4_req1_words", wr_cnt[1], 2);
        wait_src(2, 2, 20, "t4_req2_words");

        // asynchronous reset mid-burst
        reset_dut();
        for (int j = 0; j < 4; j++) push_word(0, DW'(j + 8));
        apply_inputs();
        wait_src(0, 1, 20, "t5_one_word");
        bus.fifo_full = 1'b1;
        @(negedge wclk); #1;
        bus.fifo_full = 1'b0;
        chk("t5_stall_pre", int'(bus.stall_cnt), 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_gnt", int'(bus.gnt), 0);
        chk("t5_rst_w_en", int'(bus.fifo_w_en), 0);
        chk("t5_rst_busy", int'(bus.busy), 0);
        chk("t5_rst_stall", int'(bus.stall_cnt), 0);
        repeat (2) @(negedge wclk);
        #1;
        clear_srcs();
        for (int i = 0; i < NREQ; i++) begin
            push_word(i, DW'(i)); push_word(i, DW'(i + 4));
        end
        apply_inputs();
        rstn = 1'b1;
        clear_logs();
        @(negedge wclk); #1;
        chk("t5_first_gnt", int'(bus.gnt), 1);

        // almost-full throttling of new grants
        reset_dut();
        bus.fifo_amf = 1'b1;
        for (int j = 0; j < 4; j++) push_word(0, DW'(j + 2));
        apply_inputs();
        @(negedge wclk); #1;
        chk("t6_gnt_c1", int'(bus.gnt), THR ? 0 : 1);
        repeat (4) @(negedge wclk);
        #1;
        chk("t6_stall", int'(bus.stall_cnt), THR ? 5 : 0);
        chk("t6_gnt_c5", int'(bus.gnt), 0);
        bus.fifo_amf = 1'b0;
        @(negedge wclk); #1;
        chk("t6_gnt_after", int'(bus.gnt), THR ? 1 : 0);
        wait_src(0, 4, 20, "t6_words");

        // randomized traffic
        reset_dut();
        rand_mode = 1'b1;
        repeat (4000) @(negedge wclk);
        #1;
        rand_mode     = 1'b0;
        bus.fifo_full = 1'b0;
        bus.fifo_amf  = 1'b0;
        pause         = '0;
        clear_srcs();
        apply_inputs();
        repeat (4) @(negedge wclk);
        #1;
        chk("final_sb_empty", exp_q.size(), 0);
        chk("stall_saturated", int'(bus.stall_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
